// File: rtl/word_cache.sv
// word_cache: direct-mapped, write-through, no-write-allocate cache that sits
// between a word-granular core port and a line-granular (16 B) memory port.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   mem_read/mem_write    core request, held until the one-cycle mem_resp
//   mem_byte_enable       write lanes, bit i = byte i
//   mem_address           byte address (bits [1:0] ignored)
//   mem_wdata             lane-aligned write data
//   mem_resp/mem_rdata    completion pulse and read word
//   pmem_read             line fill request, held until pmem_resp
//   pmem_write            single-word write-through, held until pmem_resp
//   pmem_address          line-aligned for fills, word-aligned for writes
//   pmem_wdata/pmem_byte_enable  write-through data and lanes
//   pmem_resp/pmem_rdata  memory completion and 128-bit fill line
module word_cache #(
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [31:0]  pmem_wdata,
  output logic [3:0]   pmem_byte_enable,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t         state_q, state_d;
  logic [29:0]    req_addr_q, req_addr_d;   // captured word address
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     be_q, be_d;
  logic           mem_resp_q, mem_resp_d;
  logic [31:0]    mem_rdata_q, mem_rdata_d;
  logic           pmem_read_q, pmem_read_d;
  logic           pmem_write_q, pmem_write_d;
  logic [31:0]    pmem_address_q, pmem_address_d;
  logic [SETS-1:0] valid_q, valid_d;

  logic [TW-1:0]  tag_q  [SETS];
  logic [127:0]   data_q [SETS];

  logic           line_we;
  logic [127:0]   line_data;

  logic [IW-1:0]  in_idx, req_idx;
  logic [TW-1:0]  in_tag, req_tag;
  logic [1:0]     in_off, req_off;
  logic           in_hit, req_hit;
  logic           unused_addr_bits;

  assign in_idx  = mem_address[4 +: IW];
  assign in_tag  = mem_address[31 -: TW];
  assign in_off  = mem_address[3:2];
  assign req_idx = req_addr_q[2 +: IW];
  assign req_tag = req_addr_q[29 -: TW];
  assign req_off = req_addr_q[1:0];
  assign in_hit  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^mem_address[1:0];

  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    valid_d        = valid_q;
    line_we        = 1'b0;
    line_data      = data_q[req_idx];
    unique case (state_q)
      IDLE: begin
        // write wins when both request lines are high
        if (mem_write) begin
          state_d        = WRITE;
          req_addr_d     = mem_address[31:2];
          wdata_d        = mem_wdata;
          be_d           = mem_byte_enable;
          pmem_write_d   = 1'b1;
          pmem_address_d = {mem_address[31:2], 2'b00};
        end else if (mem_read) begin
          if (in_hit) begin
            state_d     = RESP;
            mem_resp_d  = 1'b1;
            mem_rdata_d = data_q[in_idx][{in_off, 5'b0} +: 32];
          end else begin
            state_d        = FILL;
            req_addr_d     = mem_address[31:2];
            wdata_d        = mem_wdata;
            be_d           = mem_byte_enable;
            pmem_read_d    = 1'b1;
            pmem_address_d = {mem_address[31:4], 4'b0000};
          end
        end
      end
      FILL: begin
        if (pmem_resp) begin
          state_d          = RESP;
          pmem_read_d      = 1'b0;
          line_we          = 1'b1;
          line_data        = pmem_rdata;
          valid_d[req_idx] = 1'b1;
          mem_resp_d       = 1'b1;
          mem_rdata_d      = pmem_rdata[{req_off, 5'b0} +: 32];
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          state_d      = RESP;
          pmem_write_d = 1'b0;
          mem_resp_d   = 1'b1;
          // no allocate: only an already-resident line absorbs the write
          if (req_hit) begin
            line_we = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (be_q[b]) line_data[{req_off, 5'b0} + 7'(8 * b) +: 8] = wdata_q[8*b +: 8];
            end
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      req_addr_q     <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      valid_q        <= valid_d;
    end
  end

  // tags and data carry no reset; valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= line_data;
    end
  end

  assign mem_resp         = mem_resp_q;
  assign mem_rdata        = mem_rdata_q;
  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;

endmodule

// File: tb/tb_word_cache.sv
// tb_word_cache: randomized self-checking bench for word_cache. The bench acts
// as physical memory (word map with a hashed default) and models the cache as
// a transparent copy of memory plus a per-set valid/tag table deciding hit/miss.
module tb_word_cache;
  localparam int SETS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]   mem_byte_enable = '0;
  logic [31:0]  mem_address = '0, mem_wdata = '0;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address, pmem_wdata;
  logic [3:0]   pmem_byte_enable;
  logic         pmem_resp = 1'b0;
  logic [127:0] pmem_rdata = '0;

  word_cache #(.SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory and cache model ----------------
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[13:0], 2'b01, ~a[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  bit          m_valid [SETS];
  int unsigned m_tag   [SETS];

  bit          exp_is_read = 1'b0;
  bit          exp_pmem = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_rdata = '0;
  int          resp_expected = 0;

  // ---------------- memory responder ----------------
  int          cyc = 0;
  int          lat = -1;
  int          fixed_lat = -1;
  int          fill_cnt = 0, wr_cnt = 0, start_cyc = 0;
  logic [31:0] fill_addr = '0, wr_addr = '0, wr_data = '0, wmask;
  logic [3:0]  wr_be = '0;
  bit          stray_req = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #3;
    pmem_resp = 1'b0;
    if (!rst) lat = -1;
    else if (pmem_read || pmem_write) begin
      if (lat < 0) begin
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        start_cyc = cyc;
        if (pmem_read) begin
          fill_cnt++;
          fill_addr = pmem_address;
        end else begin
          wr_cnt++;
          wr_addr = pmem_address;
          wr_be   = pmem_byte_enable;
          wr_data = pmem_wdata;
        end
      end
      if (lat == 0) begin
        pmem_resp = 1'b1;
        if (pmem_read) begin
          for (int k = 0; k < 4; k++) pmem_rdata[32*k +: 32] = mem_rd(pmem_address[31:2] + 30'(k));
        end else begin
          wmask = {{8{pmem_byte_enable[3]}}, {8{pmem_byte_enable[2]}},
                   {8{pmem_byte_enable[1]}}, {8{pmem_byte_enable[0]}}};
          mem[pmem_address[31:2]] = (mem_rd(pmem_address[31:2]) & ~wmask) | (pmem_wdata & wmask);
        end
        lat = -1;
      end else lat--;
    end else if (stray_req) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      stray_req  = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        p_read = 0, p_write = 0, p_resp = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_be = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (mem_resp) begin
        chk("resp_expected", 32'(resp_expected > 0), 32'd1);
        if (resp_expected > 0) resp_expected--;
        if (exp_is_read) last_rdata = exp_rdata;
        if (exp_pmem) chk("resp_after_pmem_resp", 32'(p_resp), 32'd1);
      end
      chk("mem_rdata", mem_rdata, last_rdata);
      if (pmem_read || pmem_write) begin
        chk("pmem_rw_exclusive", 32'(pmem_read & pmem_write), 32'd0);
        if (p_read || p_write) begin
          chk("stable_read", 32'(pmem_read), 32'(p_read));
          chk("stable_write", 32'(pmem_write), 32'(p_write));
          chk("stable_addr", pmem_address, p_addr);
          chk("stable_wdata", pmem_wdata, p_wdata);
          chk("stable_be", 32'(pmem_byte_enable), 32'(p_be));
        end
      end
    end
    p_read  = pmem_read;
    p_write = pmem_write;
    p_resp  = pmem_resp;
    p_addr  = pmem_address;
    p_wdata = pmem_wdata;
    p_be    = pmem_byte_enable;
  end

  // ---------------- request driver ----------------
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdata, output int fills);
    int          idx, issue, waited;
    int unsigned tag;
    bit          hit, done;
    idx = int'((addr >> 4) % SETS);
    tag = addr >> (4 + $clog2(SETS));
    hit = m_valid[idx] && (m_tag[idx] == tag);
    exp_is_read = !wr;
    exp_pmem    = wr || !hit;
    exp_rdata   = mem_rd(addr[31:2]);
    fill_cnt = 0;
    wr_cnt   = 0;
    resp_expected++;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    mem_read        = !wr;
    mem_write       = wr;
    issue  = cyc;
    waited = 0;
    done   = 1'b0;
    while (!done && waited < 40) begin
      @(posedge clk); #2;
      waited++;
      if (mem_resp) done = 1'b1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk("resp_timeout", 32'(done), 32'd1);
    if (!done) resp_expected = 0;
    rdata = mem_rdata;
    fills = fill_cnt;
    if (wr) begin
      chk("wr_count", wr_cnt, 1);
      chk("fill_on_write", fill_cnt, 0);
      chk("wr_addr", wr_addr, {addr[31:2], 2'b00});
      chk("wr_be", 32'(wr_be), 32'(be));
      chk("wr_data", wr_data, wd);
    end else begin
      chk("fill_count", fill_cnt, hit ? 0 : 1);
      chk("wr_on_read", wr_cnt, 0);
      if (!hit) chk("fill_addr", fill_addr, {addr[31:4], 4'b0000});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    if (exp_pmem) chk("pmem_start_cycle", start_cyc, issue + 1);
    else          chk("hit_latency", waited, 1);
    @(posedge clk); #2;
  endtask

  logic [31:0] rd;
  int          nf, waited;

  initial begin
    mem[30'h4] = 32'hAAAAAAAA;
    mem[30'h5] = 32'hBBBBBBBB;
    mem[30'h6] = 32'hCCCCCCCC;
    mem[30'h7] = 32'hDDDDDDDD;

    #1 rst = 1'b0;
    #3;
    chk("rst_mem_resp", 32'(mem_resp), 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_read", 32'(pmem_read), 0);
    chk("rst_pmem_write", 32'(pmem_write), 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_pmem_be", 32'(pmem_byte_enable), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;

    // cold miss then hit
    fixed_lat = 3;
    do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, nf);
    chk("cold_miss_data", rd, 32'hAAAAAAAA);
    chk("cold_miss_fill", nf, 1);
    chk("cold_miss_addr", fill_addr, 32'h10);
    do_req(1'b0, 32'h14, 4'h0, 32'h0, rd, nf);
    chk("hit_data", rd, 32'hBBBBBBBB);
    chk("hit_no_fill", nf, 0);

    // write hit merge
    do_req(1'b1, 32'h18, 4'b0011, 32'h12345678, rd, nf);
    chk("whit_addr", wr_addr, 32'h18);
    chk("whit_be", 32'(wr_be), 32'h3);
    do_req(1'b0, 32'h18, 4'h0, 32'h0, rd, nf);
    chk("merge_data", rd, 32'hCCCC5678);
    chk("merge_no_fill", nf, 0);

    // write miss, no allocate
    do_req(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, rd, nf);
    do_req(1'b0, 32'h200, 4'h0, 32'h0, rd, nf);
    chk("wmiss_fill", nf, 1);
    chk("wmiss_fill_addr", fill_addr, 32'h200);
    chk("wmiss_data", rd, 32'hCAFEF00D);

    // reset during a fill
    fixed_lat = 20;
    exp_is_read = 1'b1; exp_pmem = 1'b1; resp_expected = 1;
    mem_address = 32'h90; mem_read = 1'b1;
    waited = 0;
    while (!pmem_read && waited < 10) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("midfill_started", 32'(pmem_read), 1);
    #2 rst = 1'b0;
    #1;
    chk("midfill_pmem_read", 32'(pmem_read), 0);
    chk("midfill_mem_resp", 32'(mem_resp), 0);
    chk("midfill_pmem_addr", pmem_address, 0);
    chk("midfill_mem_rdata", mem_rdata, 0);
    mem_read = 1'b0;
    resp_expected = 0;
    last_rdata = '0;
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    fixed_lat = 3;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // conflict eviction on index 1
    do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, nf);
    chk("post_rst_fill", nf, 1);
    chk("post_rst_data", rd, 32'hAAAAAAAA);
    do_req(1'b0, 32'h90, 4'h0, 32'h0, rd, nf);
    chk("conflict_fill_b", nf, 1);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, nf);
    chk("conflict_fill_c", nf, 1);

    // request held through RESP re-issues only in the following IDLE cycle
    exp_is_read = 1'b1; exp_pmem = 1'b0; exp_rdata = mem_rd(30'h5);
    resp_expected = 2; fill_cnt = 0;
    mem_address = 32'h14; mem_read = 1'b1;
    @(posedge clk); #2; chk("hold_resp1", 32'(mem_resp), 1);
    @(posedge clk); #2; chk("hold_gap", 32'(mem_resp), 0);
    @(posedge clk); #2; chk("hold_resp2", 32'(mem_resp), 1);
    mem_read = 1'b0;
    @(posedge clk); #2; chk("hold_after", 32'(mem_resp), 0);
    chk("hold_no_fill", fill_cnt, 0);
    chk("hold_resp_count", resp_expected, 0);

    // stray pmem_resp in IDLE
    stray_req = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("stray_no_resp", 32'(mem_resp), 0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, nf);
    chk("stray_data", rd, 32'hAAAAAAAA);
    chk("stray_no_fill", nf, 0);

    // randomized traffic
    fixed_lat = -1;
    for (int i = 0; i < 300; i++) begin
      bit          wr;
      logic [31:0] a, wd;
      logic [3:0]  be;
      wr = ($urandom_range(0, 99) < 30);
      a  = $urandom_range(0, 255) << 2;
      be = 4'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        stray_req = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
      end
      do_req(wr, a, be, wd, rd, nf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
